// File: rtl/irq_pending_ctrl_if.sv
// Bus bundle for irq_pending_ctrl: request lines, mask access, acknowledge and status.
// master drives requests/strobes; slave is the controller itself.
interface irq_pending_ctrl_if;
  logic [3:0] req_in;
  logic       mask_we;
  logic [3:0] mask_wdata;
  logic [3:0] mask;
  logic       ack;
  logic [1:0] ack_id;
  logic [3:0] pending;
  logic       irq;
  logic [3:0] overflow;
  logic       ovf_clr;

  modport master (
    output req_in, mask_we, mask_wdata, ack, ack_id, ovf_clr,
    input  mask, pending, irq, overflow
  );

  modport slave (
    input  req_in, mask_we, mask_wdata, ack, ack_id, ovf_clr,
    output mask, pending, irq, overflow
  );
endinterface

// File: rtl/irq_pending_ctrl.sv
// Request synchroniser + sticky pending capture feeding the 4-to-2 priority encoder.
// Optional macro IRQ_LEVEL_EN selects level-sensitive capture (overflow disabled).
module irq_pending_ctrl #(
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  irq_pending_ctrl_if.slave bus
);

  logic [3:0] sync_reg [SYNC_STAGES];
  logic [3:0] sync_out;
  logic [3:0] hist_reg;
  logic [3:0] pend_reg;
  logic [3:0] pend_next;
  logic [3:0] mask_reg;
  logic [3:0] ovf_reg;
  logic [3:0] ovf_next;
  logic [3:0] ack_vec;

  assign sync_out = sync_reg[SYNC_STAGES-1];

  always_comb begin
    ack_vec = '0;
    if (bus.ack) ack_vec[bus.ack_id] = 1'b1;
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_bit
`ifdef IRQ_LEVEL_EN
      assign pend_next[gi] = sync_out[gi] | (pend_reg[gi] & ~ack_vec[gi]);
      assign ovf_next[gi]  = 1'b0;
`else
      logic rise;
      assign rise = sync_out[gi] & ~hist_reg[gi];
      // Set beats ack; an edge landing on an un-acked pending bit is an overflow.
      assign pend_next[gi] = rise | (pend_reg[gi] & ~ack_vec[gi]);
      assign ovf_next[gi]  = (rise & pend_reg[gi] & ~ack_vec[gi]) |
                             (ovf_reg[gi] & ~bus.ovf_clr);
`endif
    end
  endgenerate

`ifdef IRQ_LEVEL_EN
  logic unused_level;
  assign unused_level = ^{bus.ovf_clr, hist_reg};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_reg[k] <= '0;
      hist_reg <= '0;
      pend_reg <= '0;
      mask_reg <= '0;
      ovf_reg  <= '0;
    end else begin
      sync_reg[0] <= bus.req_in;
      for (int k = 1; k < SYNC_STAGES; k++) sync_reg[k] <= sync_reg[k-1];
      hist_reg <= sync_out;
      pend_reg <= pend_next;
      ovf_reg  <= ovf_next;
      if (bus.mask_we) mask_reg <= bus.mask_wdata;
    end
  end

  // Mask gates visibility only; capture and ack work on the raw register.
  assign bus.pending  = pend_reg & ~mask_reg;
  assign bus.irq      = |(pend_reg & ~mask_reg);
  assign bus.mask     = mask_reg;
  assign bus.overflow = ovf_reg;

endmodule
